sync_fifo_burst_rd: RTL and testbench
=====================================

# sync_fifo_burst_rd

Downstream read stage for `sync_fifo_top`. It drains the FIFO's show-ahead read port and presents the words as a valid/ready stream with a `m_last` burst marker. Full bursts of BURST_LEN beats start when the FIFO reports almost-full. After an idle timeout, any residue is flushed as single-beat bursts. A 2-entry output buffer keeps `m_ready` out of every combinational path to `fifo_rden`.

## Interface
- FIFO_WIDTH, 8: data width; must match the FIFO.
- FIFO_DEPTH, 4: FIFO depth; used only for the legality check.
- BURST_LEN, 3: beats per full burst; legal range 1 ≤ BURST_LEN ≤ FIFO_DEPTH-1.
- TIMEOUT_CYCLES, 16: non-empty idle cycles before a flush; must be ≥ 1.

- clk  in  1  clock.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- fifo_rddata  in  FIFO_WIDTH  FIFO head word; valid whenever `fifo_empty`=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_almost_full  in  1  FIFO level ≥ FIFO_DEPTH-1.
- fifo_rden  out  1  pop; the FIFO advances on the same edge.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts.
- m_data  out  FIFO_WIDTH  output word.
- m_last  out  1  final beat of a burst.
- busy  out  1  state ≠ IDLE, or the output buffer is non-empty.

## Operation
- States: IDLE, BURST, FLUSH. Encoding is an enum from the package.
- **IDLE**
  - Timer: cleared when `fifo_empty`=1; otherwise increments, saturating at TIMEOUT_CYCLES.
  - If `fifo_almost_full`=1, go to BURST with beat_cnt=0. This has priority over the timeout.
  - Else if `fifo_empty`=0 and timer = TIMEOUT_CYCLES-1, go to FLUSH.
  - The timer clears on leaving IDLE.
- **BURST**
  - Pop condition: `fifo_empty`=0 and buffer count ≠ 2.
  - Each pop increments beat_cnt. The pop with beat_cnt = BURST_LEN-1 is tagged last and returns the block to IDLE.
  - BURST_LEN ≤ FIFO_DEPTH-1 guarantees BURST_LEN words were present at entry, so a burst never starves.
- **FLUSH**
  - Pop condition: same as BURST. Every popped word is tagged last (single-beat bursts).
  - If `fifo_empty`=1, go to IDLE.
  - Else if `fifo_almost_full`=1, go to BURST with beat_cnt=0. Any cycle is a burst boundary here.
- **Pop rule:** `fifo_rden` = (state ∈ {BURST, FLUSH}) & !`fifo_empty` & (buf_cnt ≠ 2). All three terms are registered or FIFO flags, so `m_ready` never reaches `fifo_rden` combinationally.
- **Output buffer** (2-entry):
  - Pushes {`fifo_rddata`, last tag} on `fifo_rden`.
  - Pops on `m_valid` & `m_ready`.
  - A simultaneous push and pop leaves buf_cnt unchanged.
  - Strict in-order delivery.
  - `m_valid`/`m_data`/`m_last` hold stable while `m_valid`=1 and `m_ready`=0.
- **Widths:**
  - beat_cnt is $clog2(BURST_LEN) bits, minimum 1.
  - timer is $clog2(TIMEOUT_CYCLES+1) bits.
  - buf_cnt is 2 bits.
  - No counter ever wraps.
- **Reset mid-operation:** state goes to IDLE and all counters and the buffer clear. Already-popped words are discarded. The FIFO is reset by the same `rstn`.
- **Elaboration check:** `$error` if BURST_LEN or TIMEOUT_CYCLES is out of range.

## Timing
- Reset values: `fifo_rden`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0.
- `fifo_almost_full` sampled high at edge N puts the block in BURST after N. The first `fifo_rden` is asserted in the cycle after edge N, and that word shows on `m_valid` one cycle later.
- Pop-to-output latency is 1 cycle.
- With `m_ready` held at 1, throughput is 1 beat/cycle. A BURST_LEN burst occupies BURST_LEN consecutive `fifo_rden` cycles.
- With `fifo_empty`=0 continuously in IDLE and no almost-full, FLUSH is entered TIMEOUT_CYCLES cycles after the first non-empty cycle.
- With `m_ready`=0, at most 2 words are popped before `fifo_rden` drops.
- `fifo_rden` is never asserted when `fifo_empty`=1, so underflow is impossible.

## Structure
- Package `sync_fifo_pkg`:
  - `burst_rd_state_e` {IDLE, BURST, FLUSH}.
  - The buffer entry struct {data, last}, parameterised by width via the module's use.
- Sub-module `sync_fifo_skid_buf`: 2-entry valid/ready buffer with push, space flag (buf_cnt ≠ 2), stable-output rule and async active-low reset.
- The top holds only the FSM, beat counter and timer. Estimated 200–300 lines total.

## Test plan
All scenarios use `sync_fifo_top` (FIFO_DEPTH=4, FIFO_WIDTH=8) with this block at BURST_LEN=3, TIMEOUT_CYCLES=16.
- **Reset:** assert `rstn`=0 mid-cycle → all outputs 0 immediately (asynchronous); state IDLE after release.
- **Full burst:** write 0xA1, 0xA2, 0xA3 with `m_ready`=1 → `fifo_rden` high for 3 consecutive cycles; `m_data` = A1, A2, A3 on consecutive cycles; `m_last` only with A3; `busy` low afterwards.
- **Timeout flush:** write only 0x55 → no pop for 16 cycles; then a single beat 0x55 with `m_last`=1; FIFO empty; back in IDLE.
- **Backpressure:** during a burst, `m_ready`=0 → exactly 2 words buffered; `fifo_rden` low; `m_data` stable. Release `m_ready` → remaining word popped; A1, A2, A3 delivered in order with no loss or duplication.
- **Flush-to-burst:** FIFO holds 1 word and times out into FLUSH; 3 more words are written back-to-back → single last-beat on the first word; then BURST of 3 with `m_last` on the 3rd.
- **Reset mid-burst:** `rstn` low after 1 pop → outputs 0 and FIFO empty. After release, new words 0x10, 0x11, 0x12 → one clean burst with `m_last` on 0x12.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo read-side blocks.
//   burst_rd_state_e : FSM states of sync_fifo_burst_rd
//   SKID_DEPTH       : number of entries in the output skid buffer
//   burst_cnt_w()    : counter width for a modulo-n count, never below 1 bit
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } burst_rd_state_e;

  localparam int SKID_DEPTH = 2;

  function automatic int burst_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo_skid_buf.sv
// Two-entry valid/ready output buffer for the burst read stage.
// Words are pushed with their burst-last tag and delivered strictly in order.
// The head word stays stable while m_valid=1 and m_ready=0.
//   clk, rstn     : clock, asynchronous active-low reset
//   push          : write {push_data, push_last} (only issued while space=1)
//   space         : buffer not full
//   cnt           : current occupancy (0..2)
//   m_valid/m_ready/m_data/m_last : output stream
module sync_fifo_skid_buf
  import sync_fifo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  output logic         space,
  output logic [1:0]   cnt,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last
);

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } entry_t;

  entry_t     mem [SKID_DEPTH];
  entry_t     head;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] buf_cnt;
  logic       pop;

  assign pop   = m_valid & m_ready;
  assign space = (buf_cnt != 2'(SKID_DEPTH));
  assign cnt   = buf_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      // push and pop together leave the occupancy unchanged
      if (push && !pop)      buf_cnt <= buf_cnt + 2'd1;
      else if (pop && !push) buf_cnt <= buf_cnt - 2'd1;
    end
  end

  // Storage is not reset; outputs are masked by m_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: push_data, last: push_last};
  end

  assign head    = mem[rd_ptr];
  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = m_valid ? head.data : '0;
  assign m_last  = m_valid & head.last;

endmodule

// File: rtl/sync_fifo_burst_rd.sv
// Downstream read stage for sync_fifo_top. Drains the FIFO's show-ahead
// port into a valid/ready stream with an m_last burst marker. Full bursts
// of BURST_LEN beats start on almost-full; after TIMEOUT_CYCLES of
// non-empty idling the residue is flushed as single-beat bursts.
//   clk, rstn          : clock, asynchronous active-low reset
//   fifo_rddata        : FIFO head word (valid while fifo_empty=0)
//   fifo_empty         : FIFO empty flag
//   fifo_almost_full   : FIFO level >= FIFO_DEPTH-1
//   fifo_rden          : pop strobe, FIFO advances on the same edge
//   m_valid/m_ready/m_data/m_last : output stream
//   busy               : FSM not idle or output buffer occupied
module sync_fifo_burst_rd
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int BURST_LEN      = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_full,
  output logic                  fifo_rden,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int BEAT_W  = burst_cnt_w(BURST_LEN);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TMO_MAX   = TIMER_W'(TIMEOUT_CYCLES);

  if (BURST_LEN < 1 || BURST_LEN > FIFO_DEPTH - 1) begin : g_bad_burst_len
    $error("sync_fifo_burst_rd: BURST_LEN must be in 1..FIFO_DEPTH-1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sync_fifo_burst_rd: TIMEOUT_CYCLES must be >= 1");
  end

  burst_rd_state_e     state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                pop;
  logic                pop_last;
  logic                buf_space;
  logic [1:0]          buf_cnt;

  // Only registered state, the registered buffer-space flag and the FIFO
  // flag feed the pop, so m_ready never reaches fifo_rden combinationally.
  assign pop       = ((state_q == BURST) || (state_q == FLUSH)) & ~fifo_empty & buf_space;
  assign fifo_rden = pop;
  assign busy      = (state_q != IDLE) | (buf_cnt != 2'd0);

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    timer_d  = '0;
    pop_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty)
          timer_d = (timer_q == TMO_MAX) ? timer_q : timer_q + TIMER_W'(1);
        // almost-full wins over the timeout; timer clears on exit
        if (fifo_almost_full) begin
          state_d = BURST;
          beat_d  = '0;
          timer_d = '0;
        end else if (!fifo_empty && timer_q == TMO_LAST) begin
          state_d = FLUSH;
          timer_d = '0;
        end
      end
      BURST: begin
        if (pop) begin
          if (beat_q == LAST_BEAT) begin
            pop_last = 1'b1;
            state_d  = IDLE;
            beat_d   = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      FLUSH: begin
        // every flushed word is its own single-beat burst, so a new full
        // burst may begin on any cycle
        pop_last = 1'b1;
        if (fifo_empty) begin
          state_d = IDLE;
        end else if (fifo_almost_full) begin
          state_d = BURST;
          beat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      timer_q <= timer_d;
    end
  end

  sync_fifo_skid_buf #(
    .W (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .push      (pop),
    .push_data (fifo_rddata),
    .push_last (pop_last),
    .space     (buf_space),
    .cnt       (buf_cnt),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

endmodule

// File: tb/tb_sync_fifo_burst_rd.sv
// Self-checking bench for sync_fifo_burst_rd with a behavioural 4-deep
// show-ahead FIFO in front of it (BURST_LEN=3, TIMEOUT_CYCLES=16).
module tb_sync_fifo_burst_rd;

  localparam int W = 8;

  logic         clk;
  logic         rstn;
  logic [W-1:0] fifo_rddata;
  logic         fifo_empty;
  logic         fifo_almost_full;
  logic         fifo_rden;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         busy;
  logic         wr_en;
  logic [W-1:0] wr_data;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    logic [2:0][W-1:0] d;
    int                stall;
    int                nruns;
    int                run0;
    int                run1;
  } vec_t;

  exp_t   sbq [$];
  int     runs [$];
  int     hs_cyc [$];
  int     checks;
  int     errors;
  int     cyc;
  int     run;
  logic   stalled;
  logic [W:0] hold;
  vec_t   vecs [4];

  sync_fifo_burst_rd #(
    .FIFO_WIDTH     (W),
    .FIFO_DEPTH     (4),
    .BURST_LEN      (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .fifo_rddata      (fifo_rddata),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_rden        (fifo_rden),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_last           (m_last),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural show-ahead FIFO, reset by the same rstn
  logic [W-1:0] fmem [4];
  logic [1:0]   frp, fwp;
  logic [2:0]   fcnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frp  <= 2'd0;
      fwp  <= 2'd0;
      fcnt <= 3'd0;
    end else begin
      if (fifo_rden) frp <= frp + 2'd1;
      if (wr_en) begin
        fmem[fwp] <= wr_data;
        fwp       <= fwp + 2'd1;
      end
      fcnt <= fcnt + 3'(wr_en) - 3'(fifo_rden);
    end
  end

  assign fifo_rddata      = fmem[frp];
  assign fifo_empty       = (fcnt == 3'd0);
  assign fifo_almost_full = (fcnt >= 3'd3);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [W-1:0] d, input logic last);
    wr_en   = 1'b1;
    wr_data = d;
    sbq.push_back('{data: d, last: last});
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 100) begin
      tick(1);
      n++;
    end
    chk({name, "_drain"}, 32'(n < 100), 1);
  endtask

  task automatic wait_rden(input string name);
    int n;
    n = 0;
    while (!fifo_rden && n < 40) begin
      tick(1);
      n++;
    end
    chk({name, "_rden_seen"}, fifo_rden, 1);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_rden"},    fifo_rden, 0);
    chk({name, "_m_valid"}, m_valid,   0);
    chk({name, "_m_data"},  m_data,    0);
    chk({name, "_m_last"},  m_last,    0);
    chk({name, "_busy"},    busy,      0);
  endtask

  initial begin
    int r0;
    int h0;
    int n;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    run     = 0;
    stalled = 1'b0;
    hold    = '0;
    rstn    = 1'b0;
    m_ready = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;

    fork
      // output monitor / scoreboard consumer
      forever begin
        @(negedge clk);
        cyc++;
        if (!rstn) begin
          sbq.delete();
          run     = 0;
          stalled = 1'b0;
        end else begin
          if (stalled) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", {m_last, m_data}, hold);
          end
          if (fifo_rden) begin
            chk("no_underflow", fifo_empty, 0);
            run++;
          end else if (run != 0) begin
            runs.push_back(run);
            run = 0;
          end
          if (m_valid && m_ready) begin
            if (sbq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_extra_beat actual=%0h required=none", m_data);
            end else begin
              exp_t e;
              e = sbq.pop_front();
              chk("sb_data", m_data, e.data);
              chk("sb_last", m_last, e.last);
            end
            hs_cyc.push_back(cyc);
          end
          stalled = m_valid && !m_ready;
          hold    = {m_last, m_data};
        end
      end
      begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit reached");
      end
    join_none

    // reset state
    tick(3);
    chk_outputs_zero("reset");
    rstn = 1'b1;
    tick(2);
    chk("idle_busy", busy, 0);
    chk("idle_rden", fifo_rden, 0);

    // full bursts, with and without backpressure
    vecs[0] = '{d: 24'hA3A2A1, stall: 0, nruns: 1, run0: 3, run1: 0};
    vecs[1] = '{d: 24'h0FC35A, stall: 0, nruns: 1, run0: 3, run1: 0};
    vecs[2] = '{d: 24'hA3A2A1, stall: 6, nruns: 2, run0: 2, run1: 1};
    vecs[3] = '{d: 24'h8000FF, stall: 0, nruns: 1, run0: 3, run1: 0};

    for (int v = 0; v < 4; v++) begin
      r0 = runs.size();
      h0 = hs_cyc.size();
      m_ready = (vecs[v].stall == 0);
      for (int k = 0; k < 3; k++) wr(vecs[v].d[k], k == 2);
      if (vecs[v].stall != 0) begin
        tick(vecs[v].stall);
        chk($sformatf("vec%0d_bp_rden", v),    fifo_rden,  0);
        chk($sformatf("vec%0d_bp_valid", v),   m_valid,    1);
        chk($sformatf("vec%0d_bp_data", v),    m_data,     vecs[v].d[0]);
        chk($sformatf("vec%0d_bp_last", v),    m_last,     0);
        chk($sformatf("vec%0d_bp_busy", v),    busy,       1);
        chk($sformatf("vec%0d_bp_fifo_left", v), fcnt,     1);
        m_ready = 1'b1;
      end
      drain($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_nruns", v), runs.size() - r0, vecs[v].nruns);
      if (runs.size() > r0)
        chk($sformatf("vec%0d_run0", v), runs[r0], vecs[v].run0);
      if (vecs[v].nruns == 2 && runs.size() > r0 + 1)
        chk($sformatf("vec%0d_run1", v), runs[r0 + 1], vecs[v].run1);
      if (vecs[v].stall == 0 && hs_cyc.size() >= h0 + 3)
        chk($sformatf("vec%0d_consecutive", v), hs_cyc[h0 + 2] - hs_cyc[h0], 2);
      chk($sformatf("vec%0d_busy_after", v), busy, 0);
    end

    // timeout flush of a lone word
    r0 = runs.size();
    wr(8'h55, 1'b1);
    n = 0;
    while (!fifo_rden && n < 40) begin
      tick(1);
      n++;
    end
    chk("tmo_wait_cycles", n, 16);
    chk("tmo_head", fifo_rddata, 8'h55);
    drain("tmo");
    chk("tmo_fifo_empty", fifo_empty, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_run", (runs.size() > r0) ? runs[r0] : 0, 1);

    // flush of one word, then a full burst written right behind it
    r0 = runs.size();
    wr(8'h77, 1'b1);
    wait_rden("f2b_flush");
    tick(1);
    wr(8'hB1, 1'b0);
    wr(8'hB2, 1'b0);
    wr(8'hB3, 1'b1);
    drain("f2b");
    chk("f2b_nruns", runs.size() - r0, 2);
    if (runs.size() >= r0 + 2) begin
      chk("f2b_run_flush", runs[r0], 1);
      chk("f2b_run_burst", runs[r0 + 1], 3);
    end

    // asynchronous reset in the middle of a burst
    wr(8'hC1, 1'b0);
    wr(8'hC2, 1'b0);
    wr(8'hC3, 1'b1);
    wait_rden("mid_rst");
    tick(1);
    #2;
    rstn = 1'b0;
    #1;
    chk_outputs_zero("mid_rst");
    chk("mid_rst_fifo_empty", fifo_empty, 1);
    tick(2);
    rstn = 1'b1;
    tick(1);
    chk("post_rst_busy", busy, 0);
    r0 = runs.size();
    wr(8'h10, 1'b0);
    wr(8'h11, 1'b0);
    wr(8'h12, 1'b1);
    drain("post_rst");
    chk("post_rst_nruns", runs.size() - r0, 1);
    chk("post_rst_run", (runs.size() > r0) ? runs[r0] : 0, 3);
    chk("post_rst_fifo_empty", fifo_empty, 1);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
